// File: rtl/decode_issue_scoreboard.sv
// decode_issue_scoreboard
//
// Decode/issue stage for the TinyRV1 core. Fetched instructions are queued
// in a small FIFO; the head entry is decoded, checked against a 32-entry
// pending-write scoreboard, and issued in order to the lowest-indexed execute
// pipe that supports its op class. An undecodable head is discarded with a
// one-cycle illegal pulse. A squash flushes all queued, unissued entries.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   F_inst, F_pc, F_val, F_rdy   fetch handshake
//   rf_raddr0/1, rf_rdata0/1     register file read (rs1/rs2 of FIFO head)
//   X_val, X_rdy                 per-pipe issue handshake
//   X_pc, X_op1, X_op2, X_imm    shared issue data bus
//   X_uop, X_waddr, X_wen        micro-op, destination, write enable
//   cmpl_val, cmpl_waddr         per-pipe completion (pipe 0 in LSBs)
//   squash                       flush unissued instructions
//   illegal                      pulses when the head is discarded
module decode_issue_scoreboard #(
    parameter int unsigned                p_num_pipes = 2,
    parameter int unsigned                p_buf_depth = 4,
    parameter logic [4*p_num_pipes-1:0]   p_pipe_ops  = {4'b0010, 4'b1101}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              F_inst,
    input  logic [31:0]              F_pc,
    input  logic                     F_val,
    output logic                     F_rdy,
    output logic [4:0]               rf_raddr0,
    output logic [4:0]               rf_raddr1,
    input  logic [31:0]              rf_rdata0,
    input  logic [31:0]              rf_rdata1,
    output logic [p_num_pipes-1:0]   X_val,
    input  logic [p_num_pipes-1:0]   X_rdy,
    output logic [31:0]              X_pc,
    output logic [31:0]              X_op1,
    output logic [31:0]              X_op2,
    output logic [31:0]              X_imm,
    output logic [2:0]               X_uop,
    output logic [4:0]               X_waddr,
    output logic                     X_wen,
    input  logic [p_num_pipes-1:0]   cmpl_val,
    input  logic [5*p_num_pipes-1:0] cmpl_waddr,
    input  logic                     squash,
    output logic                     illegal
);

    localparam int unsigned AW = $clog2(p_buf_depth);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [3:0] CLS_ALU  = 4'b0001;
    localparam logic [3:0] CLS_MUL  = 4'b0010;
    localparam logic [3:0] CLS_MEM  = 4'b0100;
    localparam logic [3:0] CLS_CTRL = 4'b1000;

    typedef enum logic [2:0] {
        UOP_ADD  = 3'd0,
        UOP_ADDI = 3'd1,
        UOP_MUL  = 3'd2,
        UOP_LW   = 3'd3,
        UOP_SW   = 3'd4,
        UOP_JAL  = 3'd5,
        UOP_JR   = 3'd6,
        UOP_BNE  = 3'd7
    } uop_e;

    // FIFO pointers carry an extra wrap bit so full and empty stay distinct.
    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]  inst_mem_q [p_buf_depth];
    logic [31:0]  pc_mem_q   [p_buf_depth];
    logic [31:0]  pending_q, pending_d;

    logic         empty, full, enq, deq, issue;
    logic [31:0]  head_inst, head_pc;
    logic [4:0]   rs1, rs2, rd;
    logic         dec_ok, use_rs1, use_rs2, writes, wen, legal, hazard, found;
    uop_e         uop;
    logic [3:0]   cls;
    logic [31:0]  imm;
    logic [p_num_pipes-1:0] target_vec;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_inst = inst_mem_q[rd_ptr_q[AW-1:0]];
    assign head_pc   = pc_mem_q[rd_ptr_q[AW-1:0]];
    assign rs1       = head_inst[19:15];
    assign rs2       = head_inst[24:20];
    assign rd        = head_inst[11:7];

    // Decode the head: op, class, immediate format and which register fields
    // are real sources. Anything not matched stays dec_ok = 0 (illegal).
    always_comb begin
        dec_ok  = 1'b0;
        uop     = UOP_ADD;
        cls     = 4'b0000;
        imm     = 32'd0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        writes  = 1'b0;
        case (head_inst[6:0])
            7'b0110011: begin
                if (head_inst[14:12] == 3'b000 && head_inst[31:25] == 7'b0000000) begin
                    dec_ok = 1'b1; uop = UOP_ADD; cls = CLS_ALU;
                    use_rs1 = 1'b1; use_rs2 = 1'b1; writes = 1'b1;
                end else if (head_inst[14:12] == 3'b000 && head_inst[31:25] == 7'b0000001) begin
                    dec_ok = 1'b1; uop = UOP_MUL; cls = CLS_MUL;
                    use_rs1 = 1'b1; use_rs2 = 1'b1; writes = 1'b1;
                end
            end
            7'b0010011: begin
                if (head_inst[14:12] == 3'b000) begin
                    dec_ok = 1'b1; uop = UOP_ADDI; cls = CLS_ALU;
                    imm = {{20{head_inst[31]}}, head_inst[31:20]};
                    use_rs1 = 1'b1; writes = 1'b1;
                end
            end
            7'b0000011: begin
                if (head_inst[14:12] == 3'b010) begin
                    dec_ok = 1'b1; uop = UOP_LW; cls = CLS_MEM;
                    imm = {{20{head_inst[31]}}, head_inst[31:20]};
                    use_rs1 = 1'b1; writes = 1'b1;
                end
            end
            7'b0100011: begin
                if (head_inst[14:12] == 3'b010) begin
                    dec_ok = 1'b1; uop = UOP_SW; cls = CLS_MEM;
                    imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
            end
            7'b1101111: begin
                dec_ok = 1'b1; uop = UOP_JAL; cls = CLS_CTRL;
                imm = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                       head_inst[20], head_inst[30:21], 1'b0};
                writes = 1'b1;
            end
            7'b1100111: begin
                if (head_inst[14:12] == 3'b000) begin
                    dec_ok = 1'b1; uop = UOP_JR; cls = CLS_CTRL;
                    imm = {{20{head_inst[31]}}, head_inst[31:20]};
                    use_rs1 = 1'b1; writes = 1'b1;
                end
            end
            7'b1100011: begin
                if (head_inst[14:12] == 3'b001) begin
                    dec_ok = 1'b1; uop = UOP_BNE; cls = CLS_CTRL;
                    imm = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                           head_inst[30:25], head_inst[11:8], 1'b0};
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pick the lowest-indexed pipe whose class mask covers the head's class.
    // No match leaves found = 0, which makes the instruction illegal.
    always_comb begin
        target_vec = '0;
        found      = 1'b0;
        for (int i = 0; i < int'(p_num_pipes); i++) begin
            if (!found && ((p_pipe_ops[4*i +: 4] & cls) != 4'b0000)) begin
                target_vec[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign wen    = writes && (rd != 5'd0);
    assign legal  = dec_ok && found;
    assign hazard = (use_rs1 && (rs1 != 5'd0) && pending_q[rs1]) ||
                    (use_rs2 && (rs2 != 5'd0) && pending_q[rs2]) ||
                    (wen && pending_q[rd]);

    assign X_val   = (!empty && legal && !hazard && !squash && !rst) ? target_vec : '0;
    assign illegal = !empty && !legal && !squash && !rst;
    assign issue   = |(X_val & X_rdy);
    assign deq     = issue || illegal;
    assign F_rdy   = !full && !rst;
    assign enq     = F_val && F_rdy && !squash;

    assign rf_raddr0 = rs1;
    assign rf_raddr1 = rs2;
    assign X_pc      = head_pc;
    assign X_op1     = (uop == UOP_JAL) ? head_pc : ((rs1 == 5'd0) ? 32'd0 : rf_rdata0);
    assign X_op2     = (rs2 == 5'd0) ? 32'd0 : rf_rdata1;
    assign X_imm     = imm;
    assign X_uop     = uop;
    assign X_waddr   = rd;
    assign X_wen     = wen;

    // Pointer and scoreboard next state. Completions clear first so that an
    // issue setting the same bit in the same cycle wins; x0 is never pending.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pending_d = pending_q;
        if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (squash) rd_ptr_d = wr_ptr_q;
        for (int i = 0; i < int'(p_num_pipes); i++) begin
            if (cmpl_val[i]) pending_d[cmpl_waddr[5*i +: 5]] = 1'b0;
        end
        if (issue && wen) pending_d[rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Control state: cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pending_q <= pending_d;
        end
    end

    // FIFO payload storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem_q[wr_ptr_q[AW-1:0]] <= F_inst;
            pc_mem_q[wr_ptr_q[AW-1:0]]   <= F_pc;
        end
    end

endmodule
